// File: rtl/uart_fifo_wb.sv
// Wishbone-slave UART with TX/RX FIFOs, programmable baud divisor,
// sticky error flags and a maskable level interrupt.
module uart_fifo_wb #(
    parameter int SYS_CLK_FREQ = 20000000,
    parameter int BAUD         = 57600,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        wb_err_o,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FL = 1 + DATA_BITS + STOP_BITS;
    localparam logic [15:0] DIV_RST = 16'(SYS_CLK_FREQ / BAUD);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;

    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp, rx_count;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic [2:0]  ctrl;
    logic [15:0] div;
    logic rx_ovr, ferr, tx_ovf;
    logic [1:0]  reg_sel;
    logic req, acc, wr_en, rd_pop_q, tx_push, tx_ovf_set, rx_pop;
    logic [2:0]  flag_clr;
    logic [31:0] status, rdata;
    logic [FL-1:0] tx_sh;
    logic tx_busy, tx_bit_end, tx_last, tx_pop;
    logic [15:0] tx_cnt, tx_div;
    logic [3:0]  tx_bit;
    logic rx_m, rx_s;
    logic [1:0]  rx_st;
    logic [15:0] rx_cnt, rx_div;
    logic [3:0]  rx_bit;
    logic [DATA_BITS-1:0] rx_sh;
    logic rx_stop_smp, rx_push, rx_ovr_set, ferr_set;
    logic unused;

    assign wb_stall_o = 1'b0;
    assign wb_err_o   = 1'b0;
    assign unused     = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:1]};

    assign tx_empty = tx_wp == tx_rp;
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_empty = rx_wp == rx_rp;
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_count = rx_wp - rx_rp;

    // Bus decode: request cycle registers ack/data, ack cycle performs the side effects
    assign reg_sel    = wb_adr_i[3:2];
    assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign acc        = wb_cyc_i & wb_stb_i & wb_ack_o;
    assign wr_en      = acc & wb_we_i & wb_sel_i[0];
    assign tx_push    = wr_en && reg_sel == 2'd0 && !tx_full;
    assign tx_ovf_set = wr_en && reg_sel == 2'd0 && tx_full;
    assign rx_pop     = acc & rd_pop_q;
    assign flag_clr   = (wr_en && reg_sel == 2'd1) ? wb_dat_i[6:4] : 3'd0;

    // Read mux; DATA reads of an empty RX FIFO return 0
    always_comb begin
        status       = '0;
        status[0]    = ~rx_empty;
        status[1]    = tx_full;
        status[2]    = tx_empty;
        status[3]    = tx_busy;
        status[4]    = rx_ovr;
        status[5]    = ferr;
        status[6]    = tx_ovf;
        status[15:8] = 8'(rx_count);
        case (reg_sel)
            2'd0:    rdata = rx_empty ? 32'd0 : 32'(rx_mem[rx_rp[AW-1:0]]);
            2'd1:    rdata = status;
            2'd2:    rdata = {29'd0, ctrl};
            default: rdata = {16'd0, div};
        endcase
    end

    // Registered single-cycle ack; pop decision is frozen at the request so data and pop agree
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            rd_pop_q <= 1'b0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req & ~wb_we_i) ? rdata : 32'd0;
            rd_pop_q <= req & ~wb_we_i & (reg_sel == 2'd0) & ~rx_empty;
        end
    end

    // CTRL/DIV registers; divisor clamped to a minimum of 4
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl <= '0;
            div  <= DIV_RST;
        end else if (wr_en) begin
            if (reg_sel == 2'd2) ctrl <= wb_dat_i[2:0];
            if (reg_sel == 2'd3) div  <= (wb_dat_i[15:0] < 16'd4) ? 16'd4 : wb_dat_i[15:0];
        end
    end

    // Sticky flags: write-1-to-clear, a same-cycle set wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ovr <= 1'b0;
            ferr   <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            rx_ovr <= (rx_ovr & ~flag_clr[0]) | rx_ovr_set;
            ferr   <= (ferr   & ~flag_clr[1]) | ferr_set;
            tx_ovf <= (tx_ovf & ~flag_clr[2]) | tx_ovf_set;
        end
    end

    // FIFO storage (no reset needed, pointers define validity)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wb_dat_i[DATA_BITS-1:0];
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    // FIFO pointers; reset flushes both FIFOs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
        end
    end

    // TX: whole frame loaded into a shift register; next pop overlaps the last stop bit cycle
    assign tx_bit_end = tx_cnt == tx_div - 16'd1;
    assign tx_last    = tx_busy & tx_bit_end & (tx_bit == 4'(FL - 1));
    assign tx_pop     = ~tx_empty & (~tx_busy | tx_last);
    assign tx_o       = tx_sh[0];

    // TX bit timing and serialisation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sh   <= '1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_div  <= DIV_RST;
            tx_bit  <= '0;
        end else if (tx_pop) begin
            tx_sh   <= {{STOP_BITS{1'b1}}, tx_mem[tx_rp[AW-1:0]], 1'b0};
            tx_busy <= 1'b1;
            tx_cnt  <= '0;
            tx_div  <= div;
            tx_bit  <= '0;
        end else if (tx_busy) begin
            if (tx_bit_end) begin
                tx_cnt <= '0;
                tx_sh  <= {1'b1, tx_sh[FL-1:1]};
                if (tx_bit == 4'(FL - 1)) tx_busy <= 1'b0;
                else                      tx_bit  <= tx_bit + 4'd1;
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    // RX line synchroniser, idles high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
        end
    end

    assign rx_stop_smp = (rx_st == RX_STOP) && (rx_cnt == rx_div - 16'd1);
    assign rx_push     = rx_stop_smp & rx_s & ~rx_full;
    assign rx_ovr_set  = rx_stop_smp & rx_s & rx_full;
    assign ferr_set    = rx_stop_smp & ~rx_s;

    // RX FSM: mid-start check rejects glitches, then one sample per bit period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_st  <= RX_IDLE;
            rx_cnt <= '0;
            rx_div <= DIV_RST;
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            case (rx_st)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_div <= div;
                    if (!rx_s) rx_st <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == (rx_div >> 1) - 16'd1) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_st  <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == rx_div - 16'd1) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s, rx_sh[DATA_BITS-1:1]};
                        if (rx_bit == 4'(DATA_BITS - 1)) rx_st  <= RX_STOP;
                        else                             rx_bit <= rx_bit + 4'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_stop_smp) begin
                        rx_cnt <= '0;
                        rx_st  <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq_o <= 1'b0;
        else      irq_o <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty) |
                           (ctrl[2] & (rx_ovr | ferr | tx_ovf));
    end
endmodule

// File: tb/tb_uart_fifo_wb.sv
// Scoreboard bench for uart_fifo_wb: bus reads are checked by a monitor
// against a queue of expected values pushed when each read is issued.
module tb_uart_fifo_wb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, wdat = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_o;
    logic        ack, stall, err, tx, irq;
    logic        loop_en = 1'b0, rx_drv = 1'b1;
    logic        rx_line;
    int          checks = 0, failures = 0;
    logic [31:0] exp_q[$];
    string       nm_q[$];
    logic [31:0] mon_exp;
    string       mon_nm;

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_fifo_wb #(.SYS_CLK_FREQ(20000000), .BAUD(57600), .DATA_BITS(8),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .wb_stall_o(stall), .wb_err_o(err),
        .rx_i(rx_line), .tx_o(tx), .irq_o(irq)
    );

    // Read monitor: every read ack pops one expectation
    always @(negedge clk) begin
        if (ack && !we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read got=%h", dat_o);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_nm  = nm_q.pop_front();
                if (dat_o !== mon_exp) begin
                    failures++;
                    $display("FAIL %s got=%h exp=%h", mon_nm, dat_o, mon_exp);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic cwait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
        int n;
        adr = {28'd0, r, 2'd0}; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        n = 0;
        @(posedge clk); #1; n++;
        while (!ack && n < 20) begin @(posedge clk); #1; n++; end
        if (!ack) begin
            checks++; failures++;
            $display("FAIL bus_ack_timeout reg=%0d", r);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        bus(1'b1, r, d, 4'hF);
    endtask

    task automatic rd(input logic [1:0] r, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        bus(1'b0, r, 32'd0, 4'hF);
    endtask

    // One 8N1 frame at 8 clocks per bit, then 16 idle clocks
    task automatic send_frame(input logic [7:0] b, input logic stopb);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            cwait(8);
        end
        rx_drv = 1'b1;
        cwait(16);
    endtask

    initial begin
        int n;
        logic [9:0] pat;
        cwait(3);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b1;
        cwait(2);

        rd(2'd3, 32'd347, "div_reset");
        rd(2'd1, 32'h0004, "status_reset");
        rd(2'd2, 32'h0000, "ctrl_reset");

        // TX frame shape at DIV=8
        wr(2'd3, 32'd8);
        wr(2'd0, 32'hA5);
        n = 0;
        while (tx !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
        chk("tx_start_seen", {31'd0, tx}, 32'd0);
        pat = {1'b1, 8'hA5, 1'b0};
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            chk($sformatf("tx_wave_k%0d", k), {31'd0, tx}, (k < 80) ? {31'd0, pat[k/8]} : 32'd1);
        end
        rd(2'd1, 32'h0004, "status_after_frame");

        // Loopback, two back-to-back frames
        loop_en = 1'b1;
        wr(2'd0, 32'h3C);
        wr(2'd0, 32'hC3);
        rd(2'd1, 32'h0008, "status_tx_busy");
        cwait(300);
        rd(2'd1, 32'h0205, "status_rx2");
        rd(2'd0, 32'h3C, "rx_data0");
        rd(2'd0, 32'hC3, "rx_data1");
        rd(2'd0, 32'h00, "rx_empty_read");
        rd(2'd1, 32'h0004, "status_after_pops");
        loop_en = 1'b0;

        // Divisor clamp and byte-lane gating
        wr(2'd3, 32'd2);
        rd(2'd3, 32'd4, "div_clamp");
        wr(2'd3, 32'd8);
        rd(2'd3, 32'd8, "div_8");
        bus(1'b1, 2'd2, 32'h7, 4'b1110);
        rd(2'd2, 32'h0, "ctrl_sel0_gated");

        // TX-empty interrupt
        wr(2'd2, 32'h2);
        cwait(2);
        chk("irq_txie", {31'd0, irq}, 32'd1);
        wr(2'd2, 32'h0);
        cwait(2);
        chk("irq_off", {31'd0, irq}, 32'd0);

        // TX overflow with the transmitter stalled on a huge divisor
        wr(2'd3, 32'hFFFF);
        for (int i = 0; i < 17; i++) wr(2'd0, i);
        rd(2'd1, 32'h000A, "status_tx_full");
        wr(2'd0, 32'hEE);
        rd(2'd1, 32'h004A, "status_tx_ovf");
        wr(2'd1, 32'h40);
        rd(2'd1, 32'h000A, "status_ovf_cleared");
        chk("tx_in_start_bit", {31'd0, tx}, 32'd0);

        // Reset mid-frame
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_tx", {31'd0, tx}, 32'd1);
        cwait(2);
        rst = 1'b1;
        cwait(2);
        rd(2'd1, 32'h0004, "status_after_rst");
        rd(2'd3, 32'd347, "div_after_rst");
        cwait(20);
        chk("tx_idle_after_rst", {31'd0, tx}, 32'd1);

        // Framing error and error interrupt
        wr(2'd3, 32'd8);
        send_frame(8'h55, 1'b0);
        rd(2'd1, 32'h0024, "status_ferr");
        wr(2'd2, 32'h4);
        cwait(2);
        chk("irq_eie", {31'd0, irq}, 32'd1);
        rd(2'd2, 32'h4, "ctrl_eie");
        wr(2'd1, 32'h20);
        cwait(2);
        chk("irq_ferr_cleared", {31'd0, irq}, 32'd0);
        rd(2'd1, 32'h0004, "status_ferr_cleared");
        wr(2'd2, 32'h0);

        // Start-bit glitch is rejected, next frame still received
        rx_drv = 1'b0;
        cwait(2);
        rx_drv = 1'b1;
        cwait(20);
        rd(2'd1, 32'h0004, "status_glitch");
        send_frame(8'h5A, 1'b1);
        rd(2'd1, 32'h0105, "status_after_glitch");
        rd(2'd0, 32'h5A, "rx_after_glitch");

        // RX overflow: 17 frames, no reads
        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 1'b1);
        rd(2'd1, 32'h1015, "status_rx_ovr");
        wr(2'd2, 32'h1);
        cwait(2);
        chk("irq_rxie", {31'd0, irq}, 32'd1);
        rd(2'd0, 32'h10, "rx_first_of_17");
        rd(2'd1, 32'h0F15, "status_rx15");

        cwait(4);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
